// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative unsigned MUL/MULHU/DIVU/REMU, one bit per cycle, result as a one-cycle register-file write pulse
module mul_div_unit #(
    parameter int reg_word_width = 32,
    parameter int reg_addr_width = 5
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic                      START_i,
    input  logic [1:0]                OP_i,
    input  logic [reg_word_width-1:0] OPA_i,
    input  logic [reg_word_width-1:0] OPB_i,
    input  logic [reg_addr_width-1:0] DEST_i,
    output logic                      BUSY_o,
    output logic                      WRITE_EN_o,
    output logic [reg_addr_width-1:0] WRITE_REG_o,
    output logic [reg_word_width-1:0] WRITE_DATA_o
);
    localparam int W  = reg_word_width;
    localparam int CW = $clog2(W);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nx;
    logic [1:0] op;
    logic [W-1:0] opa, opb, rem, rem_nx, result;
    logic [reg_addr_width-1:0] dest;
    logic [2*W-1:0] acc, acc_nx;
    logic [CW-1:0] cnt;
    logic [W:0] sum, shifted, diff;
    logic last;
    assign BUSY_o     = state != IDLE;
    assign WRITE_EN_o = state == DONE;
    assign last       = cnt == CW'(W - 1);
    // Multiply keeps {partial product, remaining multiplier} in acc; divide keeps the quotient bits in acc's low half.
    assign sum     = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opa} : '0);
    assign shifted = {rem, acc[W-1]};
    assign diff    = shifted - {1'b0, opb};
    always_comb begin
        acc_nx   = op[1] ? {acc[2*W-1:W], acc[W-2:0], ~diff[W]} : {sum, acc[W-1:1]};
        rem_nx   = diff[W] ? shifted[W-1:0] : diff[W-1:0];
        result   = op == 2'b00 ? acc_nx[W-1:0] :
                   op == 2'b01 ? acc_nx[2*W-1:W] :
                   op == 2'b10 ? acc_nx[W-1:0] : rem_nx;
        state_nx = state == IDLE ? (START_i ? RUN : IDLE) :
                   state == RUN  ? (last ? DONE : RUN) : IDLE;
    end
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state        <= IDLE;
            cnt          <= '0;
            op           <= '0;
            opa          <= '0;
            opb          <= '0;
            dest         <= '0;
            acc          <= '0;
            rem          <= '0;
            WRITE_REG_o  <= '0;
            WRITE_DATA_o <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && START_i) begin
                op   <= OP_i;
                opa  <= OPA_i;
                opb  <= OPB_i;
                dest <= DEST_i;
                cnt  <= '0;
                acc  <= {{W{1'b0}}, OP_i[1] ? OPA_i : OPB_i};
                rem  <= '0;
            end
            if (state == RUN) begin
                acc <= acc_nx;
                rem <= rem_nx;
                cnt <= cnt + CW'(1);
                if (last) begin
                    WRITE_REG_o  <= dest;
                    WRITE_DATA_o <= result;
                end
            end
        end
    end
endmodule
